// File: rtl/leaf_out_arbiter.sv
// Round-robin, burst-locked arbiter sharing one leaf_interface output stream among NUM_REQ requesters.
// Optional per-requester transfer counters are enabled by defining LEAF_OUT_ARBITER_STATS_EN.
module leaf_out_arbiter #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_REQ      = 4,
  parameter int BURST_LEN    = 16
) (
  input  logic                            clk,
  input  logic                            ap_rst_n,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_user2arb,
  input  logic [NUM_REQ-1:0]              vld_user2arb,
  output logic [NUM_REQ-1:0]              ack_arb2user,
  output logic [PAYLOAD_BITS-1:0]         dout_arb2interface,
  output logic                            vld_arb2interface,
  input  logic                            ack_interface2arb,
  output logic [$clog2(NUM_REQ)-1:0]      grant_idx,
  output logic                            busy,
  input  logic [$clog2(NUM_REQ)-1:0]      stat_sel,
  output logic [31:0]                     stat_cnt
);

  localparam int IdxW  = $clog2(NUM_REQ);
  localparam int BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state_q, state_d;
  logic [IdxW-1:0]         grant_q, grant_d;
  logic [BeatW-1:0]        beat_q, beat_d;
  logic [PAYLOAD_BITS-1:0] out_q, out_d;
  logic                    outVld_q, outVld_d;

  logic [PAYLOAD_BITS-1:0] lane [NUM_REQ];
  logic [IdxW-1:0]         cand;
  logic [IdxW-1:0]         pickIdx;
  logic                    pickFound;
  logic                    grantAck;
  logic                    userXfer;
  logic                    lastBeat;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane[i] = din_user2arb[i*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  // Search starts just after the last grant so the previous owner goes to the back of the line.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = grant_q;
    cand      = grant_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((int'(grant_q) + k) % NUM_REQ);
      if (!pickFound && vld_user2arb[cand]) begin
        pickFound = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  assign grantAck = (state_q == GRANT) && (!outVld_q || ack_interface2arb);
  assign userXfer = grantAck && vld_user2arb[grant_q];
  assign lastBeat = (beat_q == BeatW'(BURST_LEN - 1));

  always_comb begin
    ack_arb2user = '0;
    if (grantAck) ack_arb2user[grant_q] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    beat_d   = beat_q;
    out_d    = out_q;
    outVld_d = outVld_q;
    case (state_q)
      IDLE: begin
        if (pickFound) begin
          state_d = GRANT;
          grant_d = pickIdx;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (userXfer) begin
          beat_d = beat_q + 1'b1;
          if (lastBeat) state_d = IDLE;
        end else if (!vld_user2arb[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A load in the same cycle as a drain keeps the stage full with the new word.
    if (userXfer) begin
      out_d    = lane[grant_q];
      outVld_d = 1'b1;
    end else if (outVld_q && ack_interface2arb) begin
      outVld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= IDLE;
      grant_q  <= IdxW'(NUM_REQ - 1);
      beat_q   <= '0;
      out_q    <= '0;
      outVld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      beat_q   <= beat_d;
      out_q    <= out_d;
      outVld_q <= outVld_d;
    end
  end

  assign dout_arb2interface = out_q;
  assign vld_arb2interface  = outVld_q;
  assign grant_idx          = grant_q;
  assign busy               = (state_q == GRANT);

`ifdef LEAF_OUT_ARBITER_STATS_EN
  logic [31:0] cnt_q [NUM_REQ];
  logic [31:0] statCnt_q;

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      statCnt_q <= '0;
    end else begin
      if (userXfer) cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
      if (int'(stat_sel) < NUM_REQ) statCnt_q <= cnt_q[stat_sel];
      else                          statCnt_q <= '0;
    end
  end

  assign stat_cnt = statCnt_q;
`else
  logic unusedStatSel;
  assign unusedStatSel = ^stat_sel;
  assign stat_cnt      = '0;
`endif

endmodule
